// File: rtl/dfd_apb_seq_master.sv
// rtl/dfd_apb_seq_master.sv - APB master replaying a loadable write / read-compare command table
// Define DFD_APB_SEQ_LOOP_EN to add loop_en / loop_cnt for repeated passes over the table.
module dfd_apb_seq_master #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int TMO_W  = 8,
    parameter int CNT_W  = 16,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_we,
    input  logic [IDX_W-1:0]  cmd_widx,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic              cmd_err_exp,
    input  logic [IDX_W:0]    num_cmds,
    input  logic              start,
    input  logic              abort,
`ifdef DFD_APB_SEQ_LOOP_EN
    input  logic              loop_en,
    output logic [CNT_W-1:0]  loop_cnt,
`endif
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [STRB_W-1:0] pstrb,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  tmo_cnt,
    output logic              first_fail_vld,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] last_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_CHECK, S_DONE} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

    logic              tbl_op   [DEPTH];
    logic [ADDR_W-1:0] tbl_addr [DEPTH];
    logic [DATA_W-1:0] tbl_data [DEPTH];
    logic [STRB_W-1:0] tbl_strb [DEPTH];
    logic              tbl_err  [DEPTH];

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q, num_m1_q, ff_idx_q, ld_idx;
    logic [TMO_W-1:0]  tmo_q;
    logic              psel_q, penable_q, pwrite_q, busy_q, done_q, ff_vld_q;
    logic              err_exp_q, slverr_q, tmo_hit_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [STRB_W-1:0] pstrb_q;
    logic [DATA_W-1:0] pwdata_q, exp_q, last_rdata_q;
    logic [CNT_W-1:0]  pass_cnt_q, fail_cnt_q, tmo_cnt_q, loop_cnt_q;
    logic              last_cmd, rd_mismatch, cmd_fail, wrap, load;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (cmd_we) begin
            tbl_op[cmd_widx]   <= cmd_op;
            tbl_addr[cmd_widx] <= cmd_addr;
            tbl_data[cmd_widx] <= cmd_data;
            tbl_strb[cmd_widx] <= cmd_strb;
            tbl_err[cmd_widx]  <= cmd_err_exp;
        end
    end

    always_comb begin
        last_cmd    = (idx_q == num_m1_q);
        rd_mismatch = !pwrite_q && !err_exp_q && (last_rdata_q != exp_q);
        cmd_fail    = tmo_hit_q || (slverr_q != err_exp_q) || rd_mismatch;
`ifdef DFD_APB_SEQ_LOOP_EN
        wrap        = loop_en && !cmd_fail && !ff_vld_q;
`else
        wrap        = 1'b0;
`endif
        ld_idx      = (state_q == S_CHECK && !last_cmd) ? idx_q + IDX_W'(1) : '0;
        load        = (state_q == S_IDLE && start && num_cmds != '0) ||
                      (state_q == S_CHECK && !abort && (!last_cmd || wrap));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            num_m1_q     <= '0;
            tmo_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pstrb_q      <= '0;
            pwdata_q     <= '0;
            exp_q        <= '0;
            err_exp_q    <= 1'b0;
            slverr_q     <= 1'b0;
            tmo_hit_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            loop_cnt_q   <= '0;
            ff_vld_q     <= 1'b0;
            ff_idx_q     <= '0;
            last_rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (num_cmds != '0) begin
                            pass_cnt_q <= '0;
                            fail_cnt_q <= '0;
                            tmo_cnt_q  <= '0;
                            loop_cnt_q <= '0;
                            ff_vld_q   <= 1'b0;
                            num_m1_q   <= num_cmds[IDX_W-1:0] - IDX_W'(1);
                            busy_q     <= 1'b1;
                            state_q    <= S_SETUP;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_SETUP: begin
                    if (abort) begin
                        psel_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        penable_q <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (pready) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        slverr_q  <= pslverr;
                        tmo_hit_q <= 1'b0;
                        if (!pwrite_q)
                            last_rdata_q <= prdata;
                        state_q   <= S_CHECK;
                    end else if (tmo_q == TMO_LAST) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        tmo_hit_q <= 1'b1;
                        state_q   <= S_CHECK;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_CHECK: begin
                    if (cmd_fail) begin
                        fail_cnt_q <= sat_inc(fail_cnt_q);
                        if (!ff_vld_q) begin
                            ff_vld_q <= 1'b1;
                            ff_idx_q <= idx_q;
                        end
                    end else begin
                        pass_cnt_q <= sat_inc(pass_cnt_q);
                    end
                    if (tmo_hit_q)
                        tmo_cnt_q <= sat_inc(tmo_cnt_q);
                    if (last_cmd)
                        loop_cnt_q <= sat_inc(loop_cnt_q);
                    if (load) begin
                        state_q <= S_SETUP;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Entry fields are captured here so table rewrites never disturb a transfer in flight.
            if (load) begin
                idx_q     <= ld_idx;
                psel_q    <= 1'b1;
                penable_q <= 1'b0;
                paddr_q   <= tbl_addr[ld_idx];
                pwrite_q  <= tbl_op[ld_idx];
                pstrb_q   <= tbl_op[ld_idx] ? tbl_strb[ld_idx] : '0;
                pwdata_q  <= tbl_op[ld_idx] ? tbl_data[ld_idx] : '0;
                exp_q     <= tbl_data[ld_idx];
                err_exp_q <= tbl_err[ld_idx];
            end
        end
    end

    // An abort seen in SETUP suppresses psel so the completer never observes a selected cycle.
    assign psel           = psel_q && !(state_q == S_SETUP && abort);
    assign penable        = penable_q;
    assign paddr          = paddr_q;
    assign pwrite         = pwrite_q;
    assign pstrb          = pstrb_q;
    assign pwdata         = pwdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign tmo_cnt        = tmo_cnt_q;
    assign first_fail_vld = ff_vld_q;
    assign first_fail_idx = ff_idx_q;
    assign last_rdata     = last_rdata_q;
`ifdef DFD_APB_SEQ_LOOP_EN
    assign loop_cnt       = loop_cnt_q;
`endif

endmodule

// File: tb/tb_dfd_apb_seq_master.sv
// tb/tb_dfd_apb_seq_master.sv - scoreboard bench for dfd_apb_seq_master
module tb_dfd_apb_seq_master;

    localparam int AW = 23;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int SW = 8;
    localparam int CW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, cmd_we, cmd_op, cmd_err_exp, start, abort;
    logic [IW-1:0] cmd_widx;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [SW-1:0] cmd_strb;
    logic [IW:0]   num_cmds;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite, pready, pslverr, busy, done, first_fail_vld;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] pwdata, prdata, last_rdata;
    logic [CW-1:0] pass_cnt, fail_cnt, tmo_cnt;
    logic [IW-1:0] first_fail_idx;
`ifdef DFD_APB_SEQ_LOOP_EN
    logic          loop_en;
    logic [CW-1:0] loop_cnt;
`endif

    logic [DW-1:0] rd_val;
    logic [AW-1:0] err_addr, stall_addr;
    logic          stall_en;

    assign pready  = !(stall_en && paddr == stall_addr);
    assign pslverr = (paddr == err_addr);
    assign prdata  = rd_val;

    int    checks = 0;
    int    errors = 0;
    int    setup_cnt, cmpl_cnt, stall_cyc;
    xfer_t model [16];
    xfer_t sb_q [$];

    dfd_apb_seq_master #(.TMO_W(4)) dut (
        .clk(clk), .reset(reset), .cmd_we(cmd_we), .cmd_widx(cmd_widx), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_err_exp(cmd_err_exp),
        .num_cmds(num_cmds), .start(start), .abort(abort),
`ifdef DFD_APB_SEQ_LOOP_EN
        .loop_en(loop_en), .loop_cnt(loop_cnt),
`endif
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pstrb(pstrb),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt),
        .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx), .last_rdata(last_rdata)
    );

    always @(negedge clk) begin
        if (!reset && psel && !penable) begin
            setup_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_setup got addr=%h required no transfer", paddr);
            end else begin
                xfer_t e;
                e = sb_q.pop_front();
                if (paddr !== e.addr || pwrite !== e.write || pstrb !== e.strb ||
                    (e.write && pwdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL sb_xfer got a=%h w=%b s=%h d=%h required a=%h w=%b s=%h d=%h",
                             paddr, pwrite, pstrb, pwdata, e.addr, e.write, e.strb, e.wdata);
                end
            end
        end
        if (psel && penable && pready) cmpl_cnt++;
        if (psel && penable && !pready) stall_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic op, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s, input logic e);
        cmd_we = 1'b1; cmd_widx = i[IW-1:0]; cmd_op = op; cmd_addr = a;
        cmd_data = d; cmd_strb = s; cmd_err_exp = e;
        model[i].addr = a; model[i].write = op; model[i].wdata = d; model[i].strb = op ? s : '0;
        tick();
        cmd_we = 1'b0;
    endtask

    task automatic run(input int n, input int n_setup, input bit do_abort, input bit restart,
                       output int busy_cyc, output int done_cnt);
        int tail;
        for (int i = 0; i < n_setup; i++) sb_q.push_back(model[i]);
        setup_cnt = 0; cmpl_cnt = 0; stall_cyc = 0;
        busy_cyc = 0; done_cnt = 0; tail = -1;
        num_cmds = n[IW:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 1000 && tail != 0; c++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (tail < 0) tail = 3;
            end
            if (do_abort && psel && penable && cmpl_cnt == 1) abort = 1'b1;
            start = restart && (c == 2);
            tick();
            if (tail > 0) tail--;
        end
        abort = 1'b0; start = 1'b0;
        checks++;
        if (tail != 0) begin errors++; $display("FAIL run_bound done_pulses=%0d required end of run", done_cnt); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL reset_apb got %b%b required 00", psel, penable); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b required 00", busy, done); end
        checks++; if (pass_cnt !== '0 || fail_cnt !== '0 || tmo_cnt !== '0) begin errors++; $display("FAIL reset_cnts got %0d %0d %0d required 0 0 0", pass_cnt, fail_cnt, tmo_cnt); end
        checks++; if (paddr !== '0 || pwdata !== '0 || pstrb !== '0 || pwrite !== 1'b0) begin errors++; $display("FAIL reset_bus got %h %h required 0", paddr, pwdata); end
        checks++; if (first_fail_vld !== 1'b0 || last_rdata !== '0) begin errors++; $display("FAIL reset_ff got %b %h required 0 0", first_fail_vld, last_rdata); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int bc, dc;
        rd_val = 64'hCEED1020;
        load(0, 1'b1, 23'h100, 64'hCEED1020, 8'hFF, 1'b0);
        load(1, 1'b0, 23'h100, 64'hCEED1020, 8'h00, 1'b0);
        run(2, 2, 1'b0, 1'b0, bc, dc);
        checks++; if (bc != 6) begin errors++; $display("FAIL basic_busy_cycles got %0d required 6", bc); end
        checks++; if (dc != 1) begin errors++; $display("FAIL basic_done_pulses got %0d required 1", dc); end
        checks++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd0) begin errors++; $display("FAIL basic_cnts got %0d/%0d required 2/0", pass_cnt, fail_cnt); end
        checks++; if (last_rdata !== 64'hCEED1020) begin errors++; $display("FAIL basic_last_rdata got %h required ceed1020", last_rdata); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL basic_sb_left got %0d required 0", sb_q.size()); end
    endtask

    task automatic test_mismatch();
        int bc, dc;
        rd_val = 64'h7;
        load(0, 1'b0, 23'h200, 64'h5, 8'h00, 1'b0);
        run(1, 1, 1'b0, 1'b0, bc, dc);
        checks++; if (fail_cnt !== 16'd1 || pass_cnt !== 16'd0) begin errors++; $display("FAIL mism_cnts got %0d/%0d required 0/1", pass_cnt, fail_cnt); end
        checks++; if (first_fail_vld !== 1'b1 || first_fail_idx !== 4'd0) begin errors++; $display("FAIL mism_ff got %b/%0d required 1/0", first_fail_vld, first_fail_idx); end
        checks++; if (last_rdata !== 64'h7) begin errors++; $display("FAIL mism_last_rdata got %h required 7", last_rdata); end
    endtask

    task automatic test_back_to_back();
        int bc, dc;
        rd_val = 64'hA5A5_0000_1234_5678;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) load(i, 1'b1, AW'(32'h1000 + i * 8), {$urandom, $urandom}, SW'($urandom), 1'b0);
            else            load(i, 1'b0, AW'(32'h1000 + i * 8), rd_val, 8'h00, 1'b0);
        end
        run(16, 16, 1'b0, 1'b1, bc, dc);
        checks++; if (bc != 48) begin errors++; $display("FAIL b2b_busy_cycles got %0d required 48", bc); end
        checks++; if (dc != 1) begin errors++; $display("FAIL b2b_done_pulses got %0d required 1", dc); end
        checks++; if (pass_cnt !== 16'd16 || fail_cnt !== 16'd0) begin errors++; $display("FAIL b2b_cnts got %0d/%0d required 16/0", pass_cnt, fail_cnt); end
        checks++; if (first_fail_vld !== 1'b0) begin errors++; $display("FAIL b2b_ff_cleared got %b required 0", first_fail_vld); end
        checks++; if (setup_cnt != 16 || sb_q.size() != 0) begin errors++; $display("FAIL b2b_setups got %0d required 16", setup_cnt); end
    endtask

    task automatic test_slverr();
        int bc, dc;
        rd_val = 64'h33; err_addr = 23'h300;
        load(0, 1'b0, 23'h300, 64'h33, 8'h00, 1'b1);
        load(1, 1'b0, 23'h300, 64'h33, 8'h00, 1'b0);
        load(2, 1'b0, 23'h304, 64'h33, 8'h00, 1'b1);
        run(3, 3, 1'b0, 1'b0, bc, dc);
        err_addr = '1;
        checks++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd2) begin errors++; $display("FAIL slverr_cnts got %0d/%0d required 1/2", pass_cnt, fail_cnt); end
        checks++; if (first_fail_vld !== 1'b1 || first_fail_idx !== 4'd1) begin errors++; $display("FAIL slverr_ff got %b/%0d required 1/1", first_fail_vld, first_fail_idx); end
    endtask

    task automatic test_timeout();
        int bc, dc;
        stall_en = 1'b1; stall_addr = 23'h400;
        load(0, 1'b0, 23'h400, 64'h0, 8'h00, 1'b0);
        load(1, 1'b1, 23'h500, 64'h99, 8'h0F, 1'b0);
        run(2, 2, 1'b0, 1'b0, bc, dc);
        stall_en = 1'b0;
        checks++; if (stall_cyc != 15) begin errors++; $display("FAIL tmo_access_cycles got %0d required 15", stall_cyc); end
        checks++; if (tmo_cnt !== 16'd1 || fail_cnt !== 16'd1 || pass_cnt !== 16'd1) begin errors++; $display("FAIL tmo_cnts got %0d/%0d/%0d required 1/1/1", tmo_cnt, fail_cnt, pass_cnt); end
        checks++; if (first_fail_idx !== 4'd0 || setup_cnt != 2) begin errors++; $display("FAIL tmo_ff got %0d setups %0d required 0 2", first_fail_idx, setup_cnt); end
    endtask

    task automatic test_abort();
        int bc, dc;
        for (int i = 0; i < 4; i++) load(i, 1'b1, AW'(32'h600 + i * 4), 64'(i + 1), 8'hFF, 1'b0);
        run(4, 2, 1'b1, 1'b0, bc, dc);
        checks++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd0) begin errors++; $display("FAIL abort_cnts got %0d/%0d required 2/0", pass_cnt, fail_cnt); end
        checks++; if (setup_cnt != 2 || dc != 1) begin errors++; $display("FAIL abort_setups got %0d done %0d required 2 1", setup_cnt, dc); end
    endtask

    task automatic test_zero();
        int bc, dc;
        run(0, 0, 1'b0, 1'b0, bc, dc);
        checks++; if (dc != 1 || bc != 0) begin errors++; $display("FAIL zero_run got done %0d busy %0d required 1 0", dc, bc); end
        checks++; if (pass_cnt !== 16'd2 || setup_cnt != 0) begin errors++; $display("FAIL zero_hold got %0d setups %0d required 2 0", pass_cnt, setup_cnt); end
    endtask

    task automatic test_reset_mid();
        stall_en = 1'b1; stall_addr = 23'h400;
        load(0, 1'b1, 23'h400, 64'h1, 8'h0F, 1'b0);
        sb_q.push_back(model[0]);
        num_cmds = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (psel !== 1'b1 || penable !== 1'b1) begin errors++; $display("FAIL mid_access got %b%b required 11", psel, penable); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset got %b%b%b required 000", psel, penable, busy); end
        tick(); tick();
        checks++; if (done !== 1'b0 || sb_q.size() != 0) begin errors++; $display("FAIL mid_no_done got %b required 0", done); end
        stall_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_we = 1'b0; cmd_widx = '0; cmd_op = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_strb = '0; cmd_err_exp = 1'b0; num_cmds = '0; start = 1'b0; abort = 1'b0;
        rd_val = '0; err_addr = '1; stall_addr = '0; stall_en = 1'b0;
        setup_cnt = 0; cmpl_cnt = 0; stall_cyc = 0;
`ifdef DFD_APB_SEQ_LOOP_EN
        loop_en = 1'b0;
`endif
        test_reset();
        test_basic();
        test_mismatch();
        test_back_to_back();
        test_slverr();
        test_timeout();
        test_abort();
        test_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dfd_apb_seq_master.md
Name: dfd_apb_seq_master

Overview:
- Synthesizable APB master that replays a loadable command table of writes and read-compares against any APB completer, such as the DFD MMR block.
- Used for in-silicon DFD self-check and bring-up register sequencing.
- Generalises the fixed 32-bit single-pass stimulus flow:
  - parametrised address/data width and table depth;
  - PREADY timeout;
  - PSLVERR expectation checking;
  - saturating failure counters;
  - first-fail capture.

Parameters:
- ADDR_W, 23, APB address width.
- DATA_W, 64, APB data width; must be a multiple of 8.
- DEPTH, 16, command table entries; must be a power of 2 and at least 2.
- TMO_W, 8, PREADY timeout counter width; timeout = 2^TMO_W-1 ACCESS cycles.
- CNT_W, 16, width of each status counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_we  in  1  table write strobe.
- cmd_widx  in  log2(DEPTH)  table write index.
- cmd_op  in  1  1 = write, 0 = read-compare.
- cmd_addr  in  ADDR_W  command address.
- cmd_data  in  DATA_W  write data, or expected read data.
- cmd_strb  in  DATA_W/8  PSTRB for writes.
- cmd_err_exp  in  1  PSLVERR is expected for this command.
- num_cmds  in  log2(DEPTH)+1  number of commands to run, 0..DEPTH.
- start  in  1  one-cycle run request.
- abort  in  1  stop at the next transfer boundary.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pstrb  out  DATA_W/8  APB strobes.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pass_cnt  out  CNT_W  commands that passed.
- fail_cnt  out  CNT_W  commands that failed (mismatch, unexpected error, missing error, or timeout).
- tmo_cnt  out  CNT_W  timeouts.
- first_fail_vld  out  1  a failure has been captured this run.
- first_fail_idx  out  log2(DEPTH)  index of the first failing command.
- last_rdata  out  DATA_W  prdata from the most recent completed read.

Behaviour:
- Reset:
  - all outputs are 0;
  - FSM goes to IDLE.
  - Table contents are not reset.
- FSM states: IDLE, SETUP, ACCESS, CHECK, DONE.
- Table writes:
  - accepted in any state;
  - a write takes effect the cycle after cmd_we.
  - Writing the entry currently in flight does not affect that transfer, because fields are latched in SETUP.
- IDLE:
  - on start=1 with num_cmds>0:
    - clear pass_cnt, fail_cnt, tmo_cnt and first_fail_vld;
    - set idx=0, busy=1;
    - go to SETUP.
  - On start=1 with num_cmds=0: go to DONE.
  - start is ignored while busy=1.
- SETUP:
  - latch entry[idx] into the APB outputs;
  - psel=1, penable=0;
  - pstrb=cmd_strb on writes, all-zero on reads;
  - next state ACCESS.
- ACCESS:
  - penable=1; tmo counter increments each cycle.
  - Exit on pready=1.
  - Timeout: if tmo reaches 2^TMO_W-1 with pready=0, abandon the transfer (psel=penable=0), increment tmo_cnt, and count the command as failed.
- Transfer completion (pready=1):
  - drop psel and penable in the next cycle;
  - go to CHECK.
  - On a read, capture prdata into last_rdata.
- CHECK (1 cycle) classifies the command:
  - If pslverr != err_exp: fail.
  - Otherwise, for a read with err_exp=0: prdata must equal cmd_data, else fail.
  - Otherwise: pass.
  - The matching counter increments and saturates at all-ones.
  - On the first fail of a run: first_fail_idx=idx, first_fail_vld=1.
  - Then: if idx==num_cmds-1, go to DONE; else idx++ and go to SETUP.
- abort:
  - sampled in SETUP and CHECK only; it never cuts an APB transfer mid-phase.
  - Taken in SETUP: go to DONE without driving psel.
  - Taken in CHECK: the current command is still classified, then go to DONE.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
  - Counters and first_fail fields hold until the next start.
- Latency: 3 cycles per command when pready is asserted in the first ACCESS cycle (SETUP, ACCESS, CHECK).
- An idx wrap at DEPTH is impossible because num_cmds is at most DEPTH. num_cmds is sampled at start.
- Reset asserted mid-transfer: psel and penable drop in the next cycle; no done pulse.

Optional Feature:
- Macro: DFD_APB_SEQ_LOOP_EN.
- Defined:
  - adds input loop_en (1 bit) and output loop_cnt (CNT_W).
  - If loop_en=1 at the final CHECK, idx wraps to 0 and the run repeats until abort, or until the first fail when loop_en stays high.
  - loop_cnt increments, saturating, on each completed pass.
  - Counters accumulate across loops.
  - done fires once, at exit.
- Undefined: no loop_en or loop_cnt ports; every run is single-pass.

Test Plan:
- Load write 0x100 data 0xCEED1020 strb 0xFF, then read 0x100 expecting 0xCEED1020; num_cmds=2; start, pready tied 1 -> 6 cycles busy; pass_cnt=2, fail_cnt=0; done pulses once; last_rdata=0xCEED1020.
- Read 0x200 expecting 0x5 while the completer returns 0x7 -> fail_cnt=1, first_fail_idx=0, first_fail_vld=1.
- Read with err_exp=1 and completer PSLVERR=1 -> pass; same read with err_exp=0 -> fail; read with err_exp=1 and PSLVERR=0 -> fail.
- pready held 0 with TMO_W=4 -> transfer abandoned after 15 ACCESS cycles; tmo_cnt=1, fail_cnt=1; run continues with the next command.
- abort asserted during ACCESS of cmd 1 of 4 -> cmd 1 completes and is classified; done follows; pass_cnt=2; no psel for cmds 2-3.
- With DFD_APB_SEQ_LOOP_EN, loop_en=1, 3 passing commands, abort after 10 loops -> loop_cnt=10, pass_cnt at least 30, a single done pulse.
